// File: rtl/parity_serial_tx.sv
// Serial transmitter for a data word plus its even-parity bit: start, data LSB first, parity, stop.
// Optional macro PARITY_SERIAL_TX_PAR_CHECK_EN recomputes parity at accept and flags mismatches.
module parity_serial_tx #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] data,
  input  logic            par,
  input  logic            valid,
  output logic            ready,
  output logic            tx,
  output logic            busy,
  output logic            frame_done,
  output logic            par_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PEN  = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic [SIZE-1:0] shreg_q;
  logic [SIZE-1:0] shreg_nxt;
  logic            par_q;
  logic            tx_q;
  logic            frame_done_q;
  logic            par_tx;
  logic            bit_last;

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;
  assign bit_last   = (cnt_q == CNT_LAST);
  assign shreg_nxt  = shreg_q >> 1;

`ifdef PARITY_SERIAL_TX_PAR_CHECK_EN
  logic par_err_q;
  // Line always carries the recomputed parity; the incoming bit only feeds the error flag.
  assign par_tx  = ^data;
  assign par_err = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (valid && ready) begin
      par_err_q <= (par_tx != par);
    end
  end
`else
  assign par_tx  = par;
  assign par_err = 1'b0;
`endif

  // tx and frame_done are registered: each transition loads the value of the bit being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (valid) begin
            state_q <= START;
            shreg_q <= data;
            par_q   <= par_tx;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (bit_last) begin
            state_q <= DATA;
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              shreg_q <= shreg_nxt;
              idx_q   <= idx_q + IW'(1);
              tx_q    <= shreg_nxt[0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (bit_last) begin
            state_q      <= STOP;
            cnt_q        <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= (CLKS_PER_BIT == 1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + CW'(1);
            frame_done_q <= (cnt_q == CNT_PEN);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Downstream consumer of the even-parity generator. Accepts a parallel data word plus its parity bit over a valid/ready handshake and serialises it onto a single line. Frame format: start bit, data LSB first, parity bit, stop bit. Sits between the parity stage and the board-level serial output pin.

Parameters:
SIZE, 8, data word width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data  input  SIZE  parallel word to transmit
par  input  1  parity bit for data, from the parity generator (even: ^data)
valid  input  1  upstream has data/par ready
ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idles high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of frame
par_err  output  1  parity mismatch flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tx=1, ready=1, busy=0, frame_done=0, par_err=0, shift register and counters cleared. Takes effect immediately, including mid-frame; the frame is abandoned, not resumed.
- States: IDLE, START, DATA, PARITY, STOP.
- ready = (state==IDLE); busy = (state!=IDLE). Both are combinational from state.
- Accept: on a rising edge with valid && ready, latch data into the shift register and par into the parity register; next state is START. While ready=0, valid is ignored and data/par may change freely.
- Bit timing: each state holds its bit for exactly CLKS_PER_BIT cycles, counted by a bit-clock counter of width $clog2(CLKS_PER_BIT) (minimum 1). The counter resets to 0 on every state or bit change.
- START: tx=0.
- DATA: tx = shift_reg[0]. After CLKS_PER_BIT cycles, shift right and increment the bit index. After bit SIZE-1, go to PARITY.
- PARITY: tx = latched par.
- STOP: tx=1. On the last cycle of STOP, frame_done=1 for that one cycle; next state is IDLE.
- tx is registered. It first goes low in the cycle after the accept edge.
- Frame length: (SIZE+3)*CLKS_PER_BIT cycles from the first cycle with tx=0 to the first IDLE cycle.
- Back-to-back: ready=1 in the first IDLE cycle after STOP. If valid is held high, the next START follows with no extra idle bit beyond the stop bit.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle. The counter never blocks advancement.
- tx is never X after reset. Outputs change only on clk edges or on reset assertion.

Optional Feature:
Macro PARITY_SERIAL_TX_PAR_CHECK_EN.
- Defined:
  - At accept, the block recomputes ^data and compares it with par.
  - On mismatch, par_err is set and held until the next accept or reset.
  - The transmitted parity bit is the recomputed value, not the incoming par, so the line always carries correct even parity.
- Not defined:
  - par_err is tied to 0.
  - The incoming par is transmitted unmodified.
  - No parity logic is instantiated.

Test Plan:
1. Reset, SIZE=8, CLKS_PER_BIT=4; data=8'hA5, par=0, valid pulsed one cycle -> tx bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; frame lasts 44 cycles; frame_done pulses once in cycle 44; ready returns high the next cycle.
2. valid held high with data 8'h00/par 0, then 8'hFF/par 0 -> two back-to-back frames (0,00000000,0,1 then 0,11111111,0,1); exactly one stop bit between them; ready high for exactly one cycle between frames.
3. valid asserted and data changed during a frame -> no second accept until IDLE; transmitted bits match the word latched at the accept edge.
4. rst_n dropped in the middle of DATA (bit 3) -> tx=1, busy=0, ready=1 immediately without waiting for a clock; after release, a new 8'h3C/par 0 frame transmits correctly.
5. CLKS_PER_BIT=1, data=8'h81, par=0 -> 11-cycle frame: 0,1,0,0,0,0,0,0,1,0,1.
6. With the macro defined: data=8'h01, par=0 (wrong) -> par_err=1 from the cycle after accept, parity bit on tx = 1. Next accept of 8'h03/par 0 -> par_err clears. Without the macro, same stimulus -> par_err=0 and parity bit on tx = 0.
